// File: rtl/triangle_wave_ctrl_pkg.sv
// Shared types and command-word layout for the triangle-wave sequencer.
// Command word is {periods, step, peak}, MSB to LSB.
package triangle_wave_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH   = 12;
  localparam int DEF_PERIOD_WIDTH = 8;

  function automatic int cmd_width(int data_w, int period_w);
    return 2 * data_w + period_w;
  endfunction

  function automatic int peak_lsb(int data_w);
    return 0;
  endfunction

  function automatic int step_lsb(int data_w);
    return data_w;
  endfunction

  function automatic int periods_lsb(int data_w);
    return 2 * data_w;
  endfunction

  localparam int CMD_WIDTH = cmd_width(DEF_DATA_WIDTH, DEF_PERIOD_WIDTH);

endpackage

// File: rtl/triangle_cmd_fifo.sv
// Command queue: synchronous FIFO with registered level and a flush input.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module triangle_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/triangle_wave_ctrl.sv
// Sequencer/configurator for the triangle-wave generator: queues commands and plays them in order.
// Optional replay mode under macro TRIANGLE_WAVE_CTRL_LOOP_EN (re-queues each completed command).
module triangle_wave_ctrl
  import triangle_wave_ctrl_pkg::*;
#(
  parameter int CMD_DEPTH    = 4,
  parameter int DATA_WIDTH   = 12,
  parameter int PERIOD_WIDTH = 8
) (
  input  logic                                 ref_clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 abort,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [2*DATA_WIDTH+PERIOD_WIDTH-1:0] cmd_data,
  output logic                                 cmd_err,
  output logic [$clog2(CMD_DEPTH):0]           cmd_level,
  input  logic                                 loop_en,
  output logic [DATA_WIDTH-1:0]                cfg_peak,
  output logic [DATA_WIDTH-1:0]                cfg_step,
  output logic                                 gen_load,
  output logic                                 gen_enable,
  input  logic                                 gen_period_done,
  output logic                                 busy,
  output logic                                 seq_done
);

  localparam int CMD_W       = cmd_width(DATA_WIDTH, PERIOD_WIDTH);
  localparam int PEAK_LSB    = peak_lsb(DATA_WIDTH);
  localparam int STEP_LSB    = step_lsb(DATA_WIDTH);
  localparam int PERIODS_LSB = periods_lsb(DATA_WIDTH);

  state_t                  state;
  state_t                  state_nxt;
  logic [CMD_W-1:0]        head;
  logic [CMD_W-1:0]        push_data;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    accept;
  logic                    cmd_bad;
  logic                    last_period;
  logic                    repush;
  logic [DATA_WIDTH-1:0]   in_peak;
  logic [DATA_WIDTH-1:0]   in_step;
  logic [PERIOD_WIDTH-1:0] in_periods;
  logic [PERIOD_WIDTH-1:0] cur_periods;
  logic [PERIOD_WIDTH-1:0] period_cnt;

  assign in_peak    = cmd_data[PEAK_LSB +: DATA_WIDTH];
  assign in_step    = cmd_data[STEP_LSB +: DATA_WIDTH];
  assign in_periods = cmd_data[PERIODS_LSB +: PERIOD_WIDTH];
  assign cmd_bad    = (in_step == '0) || (in_periods == '0) || (in_step > in_peak);

  assign last_period = (state == RUN) && gen_period_done && (period_cnt == PERIOD_WIDTH'(1));

`ifdef TRIANGLE_WAVE_CTRL_LOOP_EN
  assign repush = last_period && loop_en && !abort;
`else
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
  assign repush = 1'b0;
`endif

  // The replay write owns the queue tail in its cycle, so the host is held off.
  assign cmd_ready = !fifo_full && !repush;
  assign accept    = cmd_valid && cmd_ready;
  assign fifo_push = !abort && (repush || (accept && !cmd_bad));
  assign push_data = repush ? {cur_periods, cfg_step, cfg_peak} : cmd_data;

  triangle_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (ref_clk),
    .rst       (rst),
    .flush     (abort),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (cmd_level)
  );

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (last_period) begin
          if (enable && !fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      fifo_pop  = 1'b0;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state       <= IDLE;
      cfg_peak    <= '0;
      cfg_step    <= '0;
      cur_periods <= '0;
      period_cnt  <= '0;
      cmd_err     <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cmd_err  <= accept && cmd_bad && !abort;
      seq_done <= last_period && (state_nxt == IDLE) && !abort;
      if (fifo_pop) begin
        cfg_peak    <= head[PEAK_LSB +: DATA_WIDTH];
        cfg_step    <= head[STEP_LSB +: DATA_WIDTH];
        cur_periods <= head[PERIODS_LSB +: PERIOD_WIDTH];
      end
      if (abort) begin
        period_cnt <= '0;
      end else if (state == LOAD) begin
        period_cnt <= cur_periods;
      end else if ((state == RUN) && gen_period_done && (period_cnt != '0)) begin
        period_cnt <= period_cnt - 1'b1;
      end
    end
  end

  assign gen_load   = (state == LOAD);
  assign gen_enable = (state == RUN);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_triangle_wave_ctrl.sv
// Self-checking bench for triangle_wave_ctrl: directed scenarios plus randomized traffic
// against a transaction-level playlist model (command queue + remaining-period count).
module tb_triangle_wave_ctrl;

  localparam int DW    = 12;
  localparam int PW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 2 * DW + PW;
`ifdef TRIANGLE_WAVE_CTRL_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          ref_clk = 1'b0;
  logic          rst, enable, abort, cmd_valid, loop_en, gen_period_done;
  logic [CW-1:0] cmd_data;
  logic          cmd_ready, cmd_err, gen_load, gen_enable, busy, seq_done;
  logic [$clog2(DEPTH):0] cmd_level;
  logic [DW-1:0] cfg_peak, cfg_step;

  triangle_wave_ctrl #(.CMD_DEPTH(DEPTH), .DATA_WIDTH(DW), .PERIOD_WIDTH(PW)) dut (
    .ref_clk(ref_clk), .rst(rst), .enable(enable), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_err(cmd_err), .cmd_level(cmd_level), .loop_en(loop_en),
    .cfg_peak(cfg_peak), .cfg_step(cfg_step), .gen_load(gen_load),
    .gen_enable(gen_enable), .gen_period_done(gen_period_done),
    .busy(busy), .seq_done(seq_done)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct {
    int peak;
    int step;
    int periods;
  } cmd_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  cmd_t q[$];
  cmd_t cur;
  int   rem;
  bit   active;
  bit   prev_load, prev_en;
  int   dut_err_cnt;
  int   peak_log[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input int periods, input int step, input int peak);
    logic [PW-1:0] p;
    logic [DW-1:0] s, k;
    p = PW'(periods);
    s = DW'(step);
    k = DW'(peak);
    return {p, s, k};
  endfunction

  function automatic bit is_bad(input cmd_t c);
    return (c.step == 0) || (c.periods == 0) || (c.step > c.peak);
  endfunction

  // One clock: record what the DUT sees before the edge, then check the cycle after it.
  task automatic step();
    cmd_t c;
    bit   acc, pd, ab, le;
    #1;
    acc       = cmd_valid && cmd_ready;
    c.peak    = int'(cmd_data[DW-1:0]);
    c.step    = int'(cmd_data[2*DW-1:DW]);
    c.periods = int'(cmd_data[CW-1:2*DW]);
    pd        = gen_period_done && gen_enable;
    ab        = abort;
    le        = loop_en;
    @(posedge ref_clk);
    #1;
    if (cmd_err) dut_err_cnt++;
    if (ab) begin
      q.delete();
      active = 1'b0;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_seq_done", seq_done, 0);
      check_eq("abort_cmd_err", cmd_err, 0);
    end else begin
      check_eq("cmd_err", cmd_err, acc && is_bad(c));
      if (acc && !is_bad(c)) q.push_back(c);
      if (pd) begin
        check_eq("pulse_expected", rem > 0, 1);
        if (rem > 0) rem--;
        if (rem == 0 && le && LOOP) q.push_back(cur);
      end
      check_eq("seq_done", seq_done, prev_en && !busy);
      if (prev_en && !busy) begin
        check_eq("periods_at_idle", rem, 0);
        active = 1'b0;
      end
      if (gen_load) begin
        if (active) check_eq("periods_before_load", rem, 0);
        check_eq("load_has_cmd", q.size() > 0, 1);
        if (q.size() > 0) begin
          cur = q.pop_front();
          check_eq("cfg_peak", cfg_peak, cur.peak);
          check_eq("cfg_step", cfg_step, cur.step);
          rem    = cur.periods;
          active = 1'b1;
          peak_log.push_back(cur.peak);
        end
      end
      if (prev_load) check_eq("enable_after_load", gen_enable, 1);
    end
    check_eq("cmd_level", cmd_level, q.size());
    prev_load = gen_load;
    prev_en   = gen_enable;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; abort = 1'b0; cmd_valid = 1'b0; loop_en = 1'b0;
    gen_period_done = 1'b0; cmd_data = '0;
    @(posedge ref_clk); #1;
    @(posedge ref_clk); #1;
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_outputs", {cmd_err, gen_load, gen_enable, busy, seq_done}, 0);
    check_eq("rst_level", cmd_level, 0);
    check_eq("rst_cfg", {cfg_peak, cfg_step}, 0);
    rst = 1'b0;
    q.delete();
    active = 1'b0; rem = 0; prev_load = 1'b0; prev_en = 1'b0;
  endtask

  task automatic push_cmd(input logic [CW-1:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  // Play with random generator pulses until idle with nothing more to start.
  task automatic run_idle(input int budget, output int loads);
    loads = 0;
    for (int i = 0; i < budget; i++) begin
      gen_period_done = ($urandom_range(0, 2) == 0);
      step();
      if (gen_load) loads++;
      if (!busy && (!enable || q.size() == 0)) break;
    end
    gen_period_done = 1'b0;
    check_eq("run_finished", busy, 0);
  endtask

  task automatic wait_load(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (gen_load) break;
    end
    check_eq("wait_load", gen_load, 1);
  endtask

  initial begin
    int loads, errs0, held_peak;
    dut_err_cnt = 0;

    // Single command: latency, configuration, two periods, one seq_done.
    do_reset();
    enable = 1'b1;
    check_eq("t1_ready", cmd_ready, 1);
    push_cmd(mk(2, 4, 100));
    check_eq("t1_no_early_load", gen_load, 0);
    step();
    check_eq("t1_load", gen_load, 1);
    check_eq("t1_peak", cfg_peak, 100);
    check_eq("t1_step", cfg_step, 4);
    step();
    check_eq("t1_gen_enable", gen_enable, 1);
    gen_period_done = 1'b1; step();
    gen_period_done = 1'b0; step(); step();
    check_eq("t1_still_running", gen_enable, 1);
    gen_period_done = 1'b1; step();
    gen_period_done = 1'b0;
    check_eq("t1_gen_off", gen_enable, 0);
    check_eq("t1_seq_done", seq_done, 1);
    step();
    check_eq("t1_seq_done_once", seq_done, 0);

    // Fill the queue while disabled, hold off a fifth, then play all four.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_cmd(mk(1 + i % 2, 3, 50 + 10 * i));
    check_eq("t2_level_full", cmd_level, DEPTH);
    check_eq("t2_ready_low", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_data = mk(1, 1, 7);
    repeat (3) step();
    cmd_valid = 1'b0;
    check_eq("t2_held_off", cmd_level, DEPTH);
    enable = 1'b1;
    run_idle(400, loads);
    check_eq("t2_loads", loads, DEPTH);

    // Invalid commands are consumed and flagged, never stored or started.
    do_reset();
    enable = 1'b1;
    errs0 = dut_err_cnt;
    push_cmd(mk(2, 0, 100));
    push_cmd(mk(0, 4, 100));
    push_cmd(mk(2, 200, 100));
    step();
    check_eq("t3_err_pulses", dut_err_cnt - errs0, 3);
    check_eq("t3_level", cmd_level, 0);
    check_eq("t3_busy", busy, 0);

    // Abort coincident with a period pulse mid-run.
    do_reset();
    push_cmd(mk(5, 2, 80));
    push_cmd(mk(1, 1, 20));
    push_cmd(mk(1, 1, 30));
    enable = 1'b1;
    wait_load(20);
    step();
    gen_period_done = 1'b1; step();
    gen_period_done = 1'b0; step();
    check_eq("t4_level_before", cmd_level, 2);
    held_peak = int'(cfg_peak);
    gen_period_done = 1'b1; abort = 1'b1;
    step();
    gen_period_done = 1'b0; abort = 1'b0;
    check_eq("t4_gen_enable", gen_enable, 0);
    check_eq("t4_level", cmd_level, 0);
    check_eq("t4_cfg_hold", cfg_peak, held_peak);
    step();
    check_eq("t4_no_seq_done", seq_done, 0);
    check_eq("t4_stays_idle", busy, 0);

    // Dropping enable lets the current command finish and keeps the queue.
    do_reset();
    push_cmd(mk(3, 5, 60));
    push_cmd(mk(1, 7, 90));
    enable = 1'b1;
    wait_load(20);
    enable = 1'b0;
    run_idle(200, loads);
    check_eq("t5_level_kept", cmd_level, 1);
    enable = 1'b1;
    wait_load(20);
    check_eq("t5_second_peak", cfg_peak, 90);
    run_idle(200, loads);

`ifdef TRIANGLE_WAVE_CTRL_LOOP_EN
    // Replay: two commands repeat A,B,A,B.
    do_reset();
    loop_en = 1'b1;
    push_cmd(mk(1, 3, 111));
    push_cmd(mk(2, 5, 222));
    peak_log.delete();
    enable = 1'b1;
    for (int i = 0; i < 400 && peak_log.size() < 4; i++) begin
      gen_period_done = ($urandom_range(0, 2) == 0);
      step();
      if (gen_load) check_eq("t6_level_at_load", cmd_level, 1);
    end
    gen_period_done = 1'b0;
    check_eq("t6_count", peak_log.size() >= 4, 1);
    if (peak_log.size() >= 4) begin
      check_eq("t6_order0", peak_log[0], 111);
      check_eq("t6_order1", peak_log[1], 222);
      check_eq("t6_order2", peak_log[2], 111);
      check_eq("t6_order3", peak_log[3], 222);
    end
    abort = 1'b1; step(); abort = 1'b0;
    loop_en = 1'b0;
`endif

    // Randomized traffic against the playlist model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      cmd_valid       = ($urandom_range(0, 3) == 0);
      cmd_data        = mk($urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 300));
      gen_period_done = ($urandom_range(0, 2) == 0);
      step();
    end
    cmd_valid = 1'b0;
    enable    = 1'b1;
    run_idle(5000, loads);
    check_eq("rand_drained", cmd_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/triangle_wave_ctrl.md
Name: triangle_wave_ctrl

Overview:
- Sequencer and configurator for the 12-bit triangle-wave generator.
- Accepts waveform commands over a valid/ready port and queues them.
- Plays each command in turn: loads peak and step into the generator, enables it, counts completed periods, then moves to the next command.
- Sits between the host/register map and the generator in the same clock domain.

Parameters:
- CMD_DEPTH, 4, command queue depth in entries; power of 2, from 2 to 16.
- DATA_WIDTH, 12, waveform sample width; sets the widths of cfg_peak and cfg_step.
- PERIOD_WIDTH, 8, width of the per-command period count.

Ports:
- ref_clk  in  1  single clock for all logic.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  allows new commands to start; dropping it lets the current command finish.
- abort  in  1  one-cycle pulse; stops immediately and flushes the queue.
- cmd_valid  in  1  command present on cmd_data.
- cmd_ready  out  1  queue can accept a command.
- cmd_data  in  2*DATA_WIDTH+PERIOD_WIDTH  fields {periods, step, peak}, MSB to LSB.
- cmd_err  out  1  one-cycle pulse: an invalid command was dropped.
- cmd_level  out  $clog2(CMD_DEPTH)+1  number of queued entries.
- loop_en  in  1  replay mode select; used only under the optional feature.
- cfg_peak  out  DATA_WIDTH  generator peak value.
- cfg_step  out  DATA_WIDTH  generator increment.
- gen_load  out  1  one-cycle pulse: generator restarts from 0 using cfg_*.
- gen_enable  out  1  generator runs while this is high.
- gen_period_done  in  1  one-cycle pulse from the generator at the end of each full up/down period.
- busy  out  1  state is not IDLE.
- seq_done  out  1  one-cycle pulse when the queue drains and the block returns to IDLE.

Behaviour:
- Reset (synchronous, rst=1 sampled on ref_clk): state=IDLE, queue empty.
  - All outputs are 0 except cmd_ready=1.
  - cfg_peak and cfg_step reset to 0.
- Handshake:
  - A transfer occurs when cmd_valid && cmd_ready.
  - cmd_ready = !full. It is combinational from the registered level and does not depend on a same-cycle pop.
- Validation at accept: a command is invalid if step==0, periods==0, or step>peak.
  - Invalid command: it is consumed (handshake completes), not stored, and cmd_err pulses on the next cycle.
- cmd_level: updates one cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- FSM states: IDLE, LOAD, RUN.
  - IDLE -> LOAD when enable && !empty.
    - In that cycle the head is popped, and cfg_peak/cfg_step are registered, valid from the LOAD cycle.
  - LOAD: lasts one cycle.
    - gen_load=1, gen_enable=0.
    - The period counter is loaded with periods.
    - Next state is RUN.
  - RUN: gen_enable=1. Each gen_period_done decrements the counter.
    - On the pulse that moves the counter from 1 to 0, if enable && !empty: pop the next entry and go to LOAD.
    - Otherwise go to IDLE, drop gen_enable, and pulse seq_done in the IDLE-entry cycle.
- Latency: a command pushed into an empty queue while idle with enable=1 is popped on the next cycle; gen_load is high one cycle after that; gen_enable rises the cycle after gen_load.
- enable=0 during RUN: the current command completes all its periods, then the block goes to IDLE; the queue is retained.
- abort:
  - Takes priority over everything, including gen_period_done and push in the same cycle.
  - Next cycle: IDLE, gen_enable=0, queue flushed (cmd_level=0). The same-cycle push is discarded. seq_done is not pulsed.
  - cfg_peak and cfg_step hold their last values.
- Generator input rules: gen_period_done outside RUN is ignored. A gen_period_done during LOAD is ignored.
- Counters and pointers wrap modulo CMD_DEPTH. The period counter never underflows.

Optional Feature:
- Macro: TRIANGLE_WAVE_CTRL_LOOP_EN.
- Defined: when loop_en=1, each command that completes all its periods is re-pushed at the queue tail in the completion cycle.
  - The re-push takes precedence over a host push in that cycle; the host sees cmd_ready=0 in that cycle.
  - The playlist repeats until abort, or until enable=0 followed by queue drain.
- Undefined: loop_en is ignored and commands are consumed once.

Decomposition:
- Package triangle_wave_ctrl_pkg:
  - FSM state encoding: IDLE=2'd0, LOAD=2'd1, RUN=2'd2.
  - cmd_data field offsets.
  - CMD_WIDTH = 2*DATA_WIDTH+PERIOD_WIDTH.
- Sub-module triangle_cmd_fifo: synchronous FIFO, registered level, flush input.

Test Plan:
- Reset, then push {periods=2, step=4, peak=100} with enable=1 -> gen_load 2 cycles after the accept with cfg_peak=100 and cfg_step=4; gen_enable high; after 2 gen_period_done pulses, gen_enable=0 and seq_done pulses once.
- Push 4 valid commands with enable=0 (CMD_DEPTH=4) -> cmd_level=4, cmd_ready=0; a 5th cmd_valid is held off; raising enable plays all 4 back-to-back, each preceded by exactly one gen_load.
- Push step=0, then periods=0, then step=200/peak=100 -> three cmd_err pulses, cmd_level stays 0, busy stays 0.
- Mid-RUN of a periods=5 command with 2 entries queued, assert abort in the same cycle as gen_period_done -> next cycle IDLE, gen_enable=0, cmd_level=0, no seq_done.
- Deassert enable during RUN of a periods=3 command with 1 entry queued -> after 3 pulses go to IDLE with cmd_level=1; re-raising enable starts that entry.
- With TRIANGLE_WAVE_CTRL_LOOP_EN defined and loop_en=1, 2 commands -> playback order A,B,A,B; cmd_level returns to 1 after each completion.
